// File: rtl/wb_ram_slave_if.sv
// rtl/wb_ram_slave_if.sv - Wishbone classic-cycle bus bundle for wb_ram_slave
interface wb_ram_slave_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   wbs_address;
   logic [DATA_WIDTH-1:0]   wbs_writedata;
   logic [DATA_WIDTH/8-1:0] wbs_sel;
   logic [DATA_WIDTH-1:0]   wbs_readdata;
   logic                    wbs_strobe;
   logic                    wbs_cycle;
   logic                    wbs_write;
   logic                    wbs_ack;
   logic                    wbs_err;

   modport master (
      output wbs_address, wbs_writedata, wbs_sel, wbs_strobe, wbs_cycle, wbs_write,
      input  wbs_readdata, wbs_ack, wbs_err
   );

   modport slave (
      input  wbs_address, wbs_writedata, wbs_sel, wbs_strobe, wbs_cycle, wbs_write,
      output wbs_readdata, wbs_ack, wbs_err
   );
endinterface

// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone classic slave over an inferred single-port RAM
module wb_ram_slave #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_LOG2  = 12,
   parameter int BASE_ADDR   = 0,
   parameter int WAIT_STATES = 0
) (
   input logic           clk,
   input logic           reset,
   wb_ram_slave_if.slave wbs
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [ADDR_WIDTH:0] BASE_EXT  = (ADDR_WIDTH + 1)'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_ERR} state_t;

   state_t                  state;
   logic [3:0]              wait_cnt;
   logic                    trans;
   logic                    hit;
   logic                    go_ack;
   logic                    wr_en;
   logic [ADDR_WIDTH:0]     addr_ext;
   logic [ADDR_WIDTH:0]     offset;
   logic [DEPTH_LOG2-1:0]   ram_index;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // One extra bit keeps addresses below BASE_ADDR from wrapping into the window.
   assign trans     = wbs.wbs_strobe & wbs.wbs_cycle;
   assign addr_ext  = {1'b0, wbs.wbs_address};
   assign offset    = addr_ext - BASE_EXT;
   assign hit       = (addr_ext >= BASE_EXT) && (offset < DEPTH_EXT);
   assign ram_index = offset[DEPTH_LOG2-1:0];

   always_comb begin
      go_ack = 1'b0;
      case (state)
         ST_IDLE: go_ack = trans & hit & (WAIT_STATES == 0);
         ST_WAIT: go_ack = trans & (wait_cnt == 4'd0);
         default: go_ack = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trans) begin
                  if (!hit) begin
                     state <= ST_ERR;
                  end else if (WAIT_STATES == 0) begin
                     state <= ST_ACK;
                  end else begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (!trans) begin
                  state <= ST_IDLE;
               end else if (wait_cnt == 4'd0) begin
                  state <= ST_ACK;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Terminations are gated by the live request so a dropped cycle never sees them.
   assign wbs.wbs_ack = (state == ST_ACK) & trans;
   assign wbs.wbs_err = (state == ST_ERR) & trans;

   assign wr_en = (state == ST_ACK) & trans & wbs.wbs_write & ~reset;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (wbs.wbs_sel[i]) begin
               mem[ram_index][8*i +: 8] <= wbs.wbs_writedata[8*i +: 8];
            end
         end
      end
   end

   // Read data is captured on entry to ACK and held until the next read ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (go_ack && !wbs.wbs_write) begin
         rd_data <= mem[ram_index];
      end
   end

   assign wbs.wbs_readdata = rd_data;
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - scoreboard bench for wb_ram_slave (0 and 3 wait states)
module tb_wb_ram_slave;
   typedef struct {
      logic        is_err;
      logic        is_write;
      logic [31:0] data;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst [2];
   logic [15:0] m_addr [2];
   logic [31:0] m_wdata [2];
   logic [3:0]  m_sel [2];
   logic        m_stb [2];
   logic        m_cyc [2];
   logic        m_we [2];
   logic        s_ack [2];
   logic        s_err [2];
   logic [31:0] s_rdata [2];

   exp_t        sb [$];
   logic [31:0] model0 [int];
   int          checks = 0;
   int          errors = 0;

   wb_ram_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
   wb_ram_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();

   wb_ram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH_LOG2(12),
                  .BASE_ADDR(16'h0100), .WAIT_STATES(0))
      dut0 (.clk(clk), .reset(rst[0]), .wbs(bus0.slave));

   wb_ram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH_LOG2(12),
                  .BASE_ADDR(16'h0100), .WAIT_STATES(3))
      dut1 (.clk(clk), .reset(rst[1]), .wbs(bus1.slave));

   assign bus0.wbs_address   = m_addr[0];
   assign bus0.wbs_writedata = m_wdata[0];
   assign bus0.wbs_sel       = m_sel[0];
   assign bus0.wbs_strobe    = m_stb[0];
   assign bus0.wbs_cycle     = m_cyc[0];
   assign bus0.wbs_write     = m_we[0];
   assign s_ack[0]           = bus0.wbs_ack;
   assign s_err[0]           = bus0.wbs_err;
   assign s_rdata[0]         = bus0.wbs_readdata;

   assign bus1.wbs_address   = m_addr[1];
   assign bus1.wbs_writedata = m_wdata[1];
   assign bus1.wbs_sel       = m_sel[1];
   assign bus1.wbs_strobe    = m_stb[1];
   assign bus1.wbs_cycle     = m_cyc[1];
   assign bus1.wbs_write     = m_we[1];
   assign s_ack[1]           = bus1.wbs_ack;
   assign s_err[1]           = bus1.wbs_err;
   assign s_rdata[1]         = bus1.wbs_readdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Request is presented from just after a rising edge; the master keeps strobe up on return.
   task automatic xfer(input int d, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel, input logic [31:0] rexp);
      exp_t e;
      int   cnt;
      e.is_err   = !(addr >= 16'h0100 && addr < 16'h1100);
      e.is_write = wr;
      e.data     = rexp;
      e.lat      = (d == 0) ? 1 : 4;
      sb.push_back(e);
      m_addr[d]  = addr;
      m_wdata[d] = wdata;
      m_sel[d]   = sel;
      m_we[d]    = wr;
      m_stb[d]   = 1'b1;
      m_cyc[d]   = 1'b1;
      cnt = 0;
      while (cnt <= 40) begin
         @(negedge clk);
         if (s_ack[d] || s_err[d]) break;
         cnt++;
         @(posedge clk);
         #1;
      end
      e = sb.pop_front();
      check($sformatf("latency d%0d @%h", d, addr), cnt, e.lat);
      check($sformatf("ack d%0d @%h", d, addr), {31'd0, s_ack[d]}, {31'd0, !e.is_err});
      check($sformatf("err d%0d @%h", d, addr), {31'd0, s_err[d]}, {31'd0, e.is_err});
      if (!e.is_write && !e.is_err)
         check($sformatf("rdata d%0d @%h", d, addr), s_rdata[d], e.data);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int d);
      m_stb[d] = 1'b0;
      m_cyc[d] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input int d, input string tag);
      @(negedge clk);
      check({tag, " ack"}, {31'd0, s_ack[d]}, 32'd0);
      check({tag, " err"}, {31'd0, s_err[d]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] mask;
      logic [31:0] rnd;
      logic [15:0] a;
      logic [3:0]  s;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; m_addr[d] = '0; m_wdata[d] = '0; m_sel[d] = '0;
         m_stb[d] = 1'b0; m_cyc[d] = 1'b0; m_we[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset ack d%0d", d), {31'd0, s_ack[d]}, 32'd0);
         check($sformatf("reset err d%0d", d), {31'd0, s_err[d]}, 32'd0);
         check($sformatf("reset rdata d%0d", d), s_rdata[d], 32'd0);
      end
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(posedge clk);
      #1;

      // full-word write then back-to-back read, no wait states
      xfer(0, 1, 16'h0105, 32'hDEADBEEF, 4'b1111, 32'h0);
      xfer(0, 0, 16'h0105, 32'h0, 4'b1111, 32'hDEADBEEF);
      idle(0);

      // byte lanes and empty select
      xfer(0, 1, 16'h0105, 32'h0000AA00, 4'b0010, 32'h0);
      xfer(0, 0, 16'h0105, 32'h0, 4'b1111, 32'hDEADAAEF);
      xfer(0, 1, 16'h0105, 32'hFFFFFFFF, 4'b0000, 32'h0);
      xfer(0, 0, 16'h0105, 32'h0, 4'b0000, 32'hDEADAAEF);
      idle(0);

      // window edges and out-of-window errors
      xfer(0, 1, 16'h0100, 32'h0100A5A5, 4'b1111, 32'h0);
      xfer(0, 1, 16'h10FF, 32'h10FF5A5A, 4'b1111, 32'h0);
      idle(0);
      xfer(0, 1, 16'h00FF, 32'h12345678, 4'b1111, 32'h0);
      idle(0);
      xfer(0, 1, 16'h1100, 32'h12345678, 4'b1111, 32'h0);
      idle(0);
      xfer(0, 0, 16'h0100, 32'h0, 4'b1111, 32'h0100A5A5);
      xfer(0, 0, 16'h10FF, 32'h0, 4'b1111, 32'h10FF5A5A);
      xfer(0, 0, 16'hFFFF, 32'h0, 4'b1111, 32'h0);
      idle(0);

      // three wait states: single write, then back-to-back reads
      xfer(1, 1, 16'h0100, 32'h31313131, 4'b1111, 32'h0);
      idle(1);
      xfer(1, 0, 16'h0100, 32'h0, 4'b1111, 32'h31313131);
      xfer(1, 0, 16'h0100, 32'h0, 4'b1111, 32'h31313131);
      idle(1);

      // abort during wait: strobe dropped after two cycles
      xfer(1, 1, 16'h0110, 32'h01100110, 4'b1111, 32'h0);
      idle(1);
      m_addr[1] = 16'h0110; m_wdata[1] = 32'hCAFEF00D; m_sel[1] = 4'b1111;
      m_we[1] = 1'b1; m_stb[1] = 1'b1; m_cyc[1] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check_quiet(1, "abort pre");
         @(posedge clk);
         #1;
      end
      m_stb[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_quiet(1, "abort post");
         @(posedge clk);
         #1;
      end
      m_cyc[1] = 1'b0;
      xfer(1, 0, 16'h0110, 32'h0, 4'b1111, 32'h01100110);
      idle(1);

      // reset in the middle of a waited write
      xfer(1, 1, 16'h0120, 32'h01200120, 4'b1111, 32'h0);
      idle(1);
      xfer(1, 0, 16'h0120, 32'h0, 4'b1111, 32'h01200120);
      idle(1);
      m_addr[1] = 16'h0120; m_wdata[1] = 32'h55AA55AA; m_sel[1] = 4'b1111;
      m_we[1] = 1'b1; m_stb[1] = 1'b1; m_cyc[1] = 1'b1;
      @(posedge clk);
      #1;
      rst[1] = 1'b1;
      #1;
      check("midreset ack", {31'd0, s_ack[1]}, 32'd0);
      check("midreset err", {31'd0, s_err[1]}, 32'd0);
      check("midreset rdata", s_rdata[1], 32'd0);
      @(posedge clk);
      #1;
      m_stb[1] = 1'b0;
      m_cyc[1] = 1'b0;
      rst[1] = 1'b0;
      @(posedge clk);
      #1;
      xfer(1, 0, 16'h0120, 32'h0, 4'b1111, 32'h01200120);
      idle(1);

      // randomised byte-lane traffic against a word model
      for (int i = 0; i < 4; i++) begin
         rnd = $urandom;
         a = 16'h0200 + 16'(i);
         model0[int'(a)] = rnd;
         xfer(0, 1, a, rnd, 4'b1111, 32'h0);
      end
      idle(0);
      for (int i = 0; i < 24; i++) begin
         a   = 16'h0200 + 16'($urandom_range(0, 3));
         s   = 4'($urandom_range(0, 15));
         rnd = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s[b]}};
            model0[int'(a)] = (model0[int'(a)] & ~mask) | (rnd & mask);
            xfer(0, 1, a, rnd, s, 32'h0);
         end else begin
            xfer(0, 0, a, rnd, s, model0[int'(a)]);
         end
         if ($urandom_range(0, 2) == 0) idle(0);
      end
      idle(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
